// File: rtl/load_store_unit_if.sv
// Bundle of the core request/response and data-memory signals around the
// load/store unit. The slave view is the unit itself; the master view is
// the environment (core plus data memory) that talks to it.
interface load_store_unit_if #(
    parameter int MEM_ADDR_W = 5
);
    // Core request
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_is_store;
    logic [2:0]            req_funct3;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    // Core response
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_misalign;
    logic                  resp_timeout;
    // Data memory
    logic                  mem_req;
    logic                  mem_we;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [3:0]            mem_be;
    logic [31:0]           mem_wdata;
    logic                  mem_ack;
    logic [31:0]           mem_rdata;

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_misalign, resp_timeout,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_misalign, resp_timeout,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: turns a byte-addressed RV32I load/store into a
// word-addressed, byte-enabled req/ack memory access with a timeout, and
// extends load data. Illegal or misaligned accesses never reach memory.
module load_store_unit #(
    parameter int MEM_ADDR_W = 5,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              reset,
    load_store_unit_if.slave  bus
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  is_store_q, is_store_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            lane_q, lane_d;

    logic                  resp_valid_q, resp_valid_d;
    logic [31:0]           resp_rdata_q, resp_rdata_d;
    logic                  resp_misalign_q, resp_misalign_d;
    logic                  resp_timeout_q, resp_timeout_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]            mem_be_q, mem_be_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;

    // Unsupported funct3 or a size/alignment clash.
    function automatic logic bad_req(input logic st, input logic [2:0] f3, input logic [1:0] a);
        logic illegal;
        if (st) illegal = (f3 != 3'b000) && (f3 != 3'b001) && (f3 != 3'b010);
        else    illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        return illegal || ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    endfunction

    function automatic logic [3:0] be_of(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Store data is replicated across lanes so the byte enables pick it out.
    function automatic logic [31:0] wdata_of(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] rd);
        logic [31:0] sh;
        case (f3[1:0])
            2'b00: begin
                sh = rd >> {a, 3'b000};
                return f3[2] ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            end
            2'b01: begin
                sh = rd >> {a[1], 4'b0000};
                return f3[2] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            end
            default: return rd;
        endcase
    endfunction

    // Next-state and registered-output decode.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        is_store_d      = is_store_q;
        funct3_d        = funct3_q;
        lane_d          = lane_q;
        resp_valid_d    = 1'b0;
        resp_rdata_d    = 32'b0;
        resp_misalign_d = 1'b0;
        resp_timeout_d  = 1'b0;
        mem_req_d       = mem_req_q;
        mem_we_d        = mem_we_q;
        mem_addr_d      = mem_addr_q;
        mem_be_d        = mem_be_q;
        mem_wdata_d     = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    is_store_d = bus.req_is_store;
                    funct3_d   = bus.req_funct3;
                    lane_d     = bus.req_addr[1:0];
                    if (bad_req(bus.req_is_store, bus.req_funct3, bus.req_addr[1:0])) begin
                        state_d         = RESP;
                        resp_valid_d    = 1'b1;
                        resp_misalign_d = 1'b1;
                    end else begin
                        state_d     = ACCESS;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.req_is_store;
                        mem_addr_d  = bus.req_addr[MEM_ADDR_W+1:2];
                        mem_be_d    = be_of(bus.req_funct3, bus.req_addr[1:0]);
                        mem_wdata_d = wdata_of(bus.req_funct3, bus.req_wdata);
                    end
                end
            end
            ACCESS: begin
                if (bus.mem_ack) begin
                    state_d      = RESP;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    if (!is_store_q) resp_rdata_d = load_ext(funct3_q, lane_q, bus.mem_rdata);
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d        = RESP;
                    mem_req_d      = 1'b0;
                    mem_we_d       = 1'b0;
                    resp_valid_d   = 1'b1;
                    resp_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            is_store_q      <= 1'b0;
            funct3_q        <= 3'b0;
            lane_q          <= 2'b0;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= 32'b0;
            resp_misalign_q <= 1'b0;
            resp_timeout_q  <= 1'b0;
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_be_q        <= 4'b0;
            mem_wdata_q     <= 32'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            is_store_q      <= is_store_d;
            funct3_q        <= funct3_d;
            lane_q          <= lane_d;
            resp_valid_q    <= resp_valid_d;
            resp_rdata_q    <= resp_rdata_d;
            resp_misalign_q <= resp_misalign_d;
            resp_timeout_q  <= resp_timeout_d;
            mem_req_q       <= mem_req_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_be_q        <= mem_be_d;
            mem_wdata_q     <= mem_wdata_d;
        end
    end

    assign bus.req_ready     = (state_q == IDLE);
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_rdata    = resp_rdata_q;
    assign bus.resp_misalign = resp_misalign_q;
    assign bus.resp_timeout  = resp_timeout_q;
    assign bus.mem_req       = mem_req_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_be        = mem_be_q;
    assign bus.mem_wdata     = mem_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with TIMEOUT=4 and a 32-word memory.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic reset;

    load_store_unit_if #(.MEM_ADDR_W(5)) mif ();

    load_store_unit #(.MEM_ADDR_W(5), .TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Observations from the last transaction
    int          resp_cyc, req_cnt, resp_cnt;
    logic [31:0] got_rdata, cap_addr, cap_wdata;
    logic        got_mis, got_to, cap_we;
    logic [3:0]  cap_be;

    // Issue one request (accepted at edge 0) and watch cycles 1..12.
    // ack_cyc = cycle in which mem_ack is driven high (0 = never).
    task automatic run(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int ack_cyc, input logic [31:0] rd);
        mif.req_is_store = st;
        mif.req_funct3   = f3;
        mif.req_addr     = a;
        mif.req_wdata    = wd;
        mif.req_valid    = 1'b1;
        @(posedge clk); #1;
        mif.req_valid = 1'b0;
        resp_cyc = 0; req_cnt = 0; resp_cnt = 0;
        got_rdata = 32'hx; got_mis = 1'bx; got_to = 1'bx;
        cap_addr = 32'b0; cap_wdata = 32'b0; cap_we = 1'b0; cap_be = 4'b0;
        for (int c = 1; c <= 12; c++) begin
            if (mif.mem_req) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    cap_addr  = 32'(mif.mem_addr);
                    cap_be    = mif.mem_be;
                    cap_we    = mif.mem_we;
                    cap_wdata = mif.mem_wdata;
                end
            end
            if (mif.resp_valid) begin
                resp_cnt++;
                if (resp_cyc == 0) begin
                    resp_cyc  = c;
                    got_rdata = mif.resp_rdata;
                    got_mis   = mif.resp_misalign;
                    got_to    = mif.resp_timeout;
                end
            end
            if (resp_cyc != 0 && c > resp_cyc) begin
                mif.mem_ack = 1'b0;
                break;
            end
            mif.mem_ack   = (c == ack_cyc);
            mif.mem_rdata = rd;
            @(posedge clk); #1;
        end
        mif.mem_ack = 1'b0;
        if (resp_cyc == 0) check("resp_seen", 32'd0, 32'd1);
    endtask

    task automatic check_err(input string tag);
        check({tag, "_cyc"},  32'(resp_cyc), 32'd1);
        check({tag, "_mis"},  32'(got_mis), 32'd1);
        check({tag, "_rd"},   got_rdata, 32'd0);
        check({tag, "_req"},  32'(req_cnt), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        mif.req_valid = 1'b0; mif.req_is_store = 1'b0; mif.req_funct3 = 3'b0;
        mif.req_addr = 32'b0; mif.req_wdata = 32'b0;
        mif.mem_ack = 1'b0; mif.mem_rdata = 32'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(mif.req_ready), 32'd1);
        check("rst_rvalid", 32'(mif.resp_valid), 32'd0);
        check("rst_mreq", 32'(mif.mem_req), 32'd0);
        check("rst_mbus", {mif.mem_wdata[27:0] | {19'b0, mif.mem_addr, mif.mem_be}}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // SW to word 2, zero-wait memory
        run(1'b1, 3'b010, 32'h0000_0008, 32'hDEAD_BEEF, 1, 32'h0);
        check("sw_cyc", 32'(resp_cyc), 32'd2);
        check("sw_addr", cap_addr, 32'd2);
        check("sw_be", 32'(cap_be), 32'hF);
        check("sw_we", 32'(cap_we), 32'd1);
        check("sw_wdata", cap_wdata, 32'hDEAD_BEEF);
        check("sw_rdata", got_rdata, 32'd0);
        check("sw_flags", {30'b0, got_mis, got_to}, 32'd0);
        check("sw_len", 32'(resp_cnt), 32'd1);

        // SB / LB / LBU at byte 1 of word 3
        run(1'b1, 3'b000, 32'h0000_000D, 32'h0000_0080, 1, 32'h0);
        check("sb_addr", cap_addr, 32'd3);
        check("sb_be", 32'(cap_be), 32'b0010);
        check("sb_wdata", cap_wdata, 32'h8080_8080);
        run(1'b0, 3'b000, 32'h0000_000D, 32'h0, 1, 32'h0000_8000);
        check("lb_we", 32'(cap_we), 32'd0);
        check("lb_be", 32'(cap_be), 32'b0010);
        check("lb_rdata", got_rdata, 32'hFFFF_FF80);
        run(1'b0, 3'b100, 32'h0000_000D, 32'h0, 1, 32'h0000_8000);
        check("lbu_rdata", got_rdata, 32'h0000_0080);

        // LH / LHU upper halfword
        run(1'b0, 3'b001, 32'h0000_0006, 32'h0, 1, 32'h8001_0000);
        check("lh_be", 32'(cap_be), 32'b1100);
        check("lh_rdata", got_rdata, 32'hFFFF_8001);
        run(1'b0, 3'b101, 32'h0000_0006, 32'h0, 1, 32'h8001_0000);
        check("lhu_rdata", got_rdata, 32'h0000_8001);

        // SH at halfword 0, address wraps past 32 words
        run(1'b1, 3'b001, 32'h0000_0084, 32'h1234_5678, 2, 32'h0);
        check("sh_addr", cap_addr, 32'd1);
        check("sh_be", 32'(cap_be), 32'b0011);
        check("sh_wdata", cap_wdata, 32'h5678_5678);
        check("sh_cyc", 32'(resp_cyc), 32'd3);

        // Error paths
        run(1'b0, 3'b010, 32'h0000_0002, 32'h0, 1, 32'hFFFF_FFFF);
        check_err("lw_mis");
        run(1'b0, 3'b011, 32'h0000_0000, 32'h0, 1, 32'hFFFF_FFFF);
        check_err("ld_f3");
        run(1'b1, 3'b001, 32'h0000_0001, 32'hFFFF_FFFF, 1, 32'h0);
        check_err("sh_mis");
        run(1'b1, 3'b100, 32'h0000_0000, 32'hFFFF_FFFF, 1, 32'h0);
        check_err("st_f3");

        // Timeout, then ack on the last allowed cycle
        run(1'b0, 3'b010, 32'h0000_0010, 32'h0, 0, 32'hAAAA_AAAA);
        check("to_req", 32'(req_cnt), 32'd4);
        check("to_cyc", 32'(resp_cyc), 32'd5);
        check("to_flag", 32'(got_to), 32'd1);
        check("to_rdata", got_rdata, 32'd0);
        run(1'b0, 3'b010, 32'h0000_0010, 32'h0, 4, 32'h1234_5678);
        check("ack4_cyc", 32'(resp_cyc), 32'd5);
        check("ack4_flag", 32'(got_to), 32'd0);
        check("ack4_rdata", got_rdata, 32'h1234_5678);

        // Reset during the second ACCESS cycle
        mif.req_is_store = 1'b0; mif.req_funct3 = 3'b010;
        mif.req_addr = 32'h0000_0010; mif.req_valid = 1'b1;
        @(posedge clk); #1;
        mif.req_valid = 1'b0;
        @(posedge clk); #1;
        check("rs_in_access", 32'(mif.mem_req), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rs_mreq", 32'(mif.mem_req), 32'd0);
        check("rs_ready", 32'(mif.req_ready), 32'd1);
        resp_cnt = 0;
        mif.mem_ack = 1'b1;  // ack in IDLE must be ignored
        for (int i = 0; i < 4; i++) begin
            if (mif.resp_valid || mif.mem_req) resp_cnt++;
            @(posedge clk); #1;
        end
        mif.mem_ack = 1'b0;
        check("rs_quiet", 32'(resp_cnt), 32'd0);
        check("idle_ack_ready", 32'(mif.req_ready), 32'd1);

        run(1'b0, 3'b010, 32'h0000_007C, 32'h0, 2, 32'hCAFE_F00D);
        check("post_rs_addr", cap_addr, 32'd31);
        check("post_rs_cyc", 32'(resp_cyc), 32'd3);
        check("post_rs_rdata", got_rdata, 32'hCAFE_F00D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
